// File: rtl/v_dsampler_ctrl.sv
// v_dsampler_ctrl: frame gate for the downsampler stream (SOF sync, frame skipping, mode latching).
// Define V_DSAMPLER_CTRL_ERR_EN to add sticky line-length and early-SOF error flags.
module v_dsampler_ctrl #(
  parameter int S_AXIS_WIDTH = 96,
  parameter int DIM_WIDTH = 16
) (
  input  logic aclk,
  input  logic areset,
  input  logic cfg_enable,
  input  logic cfg_col_down,
  input  logic cfg_line_down,
  input  logic [3:0] cfg_frame_skip,
  input  logic [DIM_WIDTH-1:0] cfg_hsize,
  input  logic [DIM_WIDTH-1:0] cfg_vsize,
`ifdef V_DSAMPLER_CTRL_ERR_EN
  input  logic cfg_err_clr,
  output logic err_eol_early,
  output logic err_eol_late,
  output logic err_sof_early,
`endif
  input  logic s_axis_tvalid,
  output logic s_axis_tready,
  input  logic [S_AXIS_WIDTH-1:0] s_axis_tdata,
  input  logic s_axis_tlast,
  input  logic s_axis_tuser,
  output logic m_axis_tvalid,
  input  logic m_axis_tready,
  output logic [S_AXIS_WIDTH-1:0] m_axis_tdata,
  output logic m_axis_tlast,
  output logic m_axis_tuser,
  output logic ds_col_down,
  output logic ds_line_down,
  output logic busy,
  output logic frame_done,
  output logic [DIM_WIDTH-1:0] frame_cnt
);
  localparam logic [1:0] IDLE = 2'd0, WAIT_SOF = 2'd1, PASS = 2'd2, DROP = 2'd3;
  logic [1:0] state_q, state_d;
  logic [3:0] skip_q, skip_d;
  logic [DIM_WIDTH-1:0] line_q, line_d, vsize_q, vsize_d, frame_cnt_q, frame_cnt_d;
  logic [DIM_WIDTH-1:0] line_e, vsize_e;
  logic col_q, col_d, lin_q, lin_d, done_q, done_d;
  logic in_frame, pass_sof, acc, sof_acc, acc_frame, pass_frame, eof;
  assign m_axis_tdata = s_axis_tdata;
  assign m_axis_tlast = s_axis_tlast;
  assign m_axis_tuser = s_axis_tuser;
  assign busy = state_q != IDLE;
  assign frame_done = done_q;
  assign frame_cnt = frame_cnt_q;
  always_comb begin
    in_frame = state_q == PASS || state_q == DROP;
    pass_sof = state_q == WAIT_SOF && s_axis_tvalid && s_axis_tuser && skip_q == 4'd0;
    m_axis_tvalid = state_q == PASS ? s_axis_tvalid : pass_sof;
    s_axis_tready = (state_q == PASS || pass_sof) ? m_axis_tready : 1'b1;
    acc = s_axis_tvalid && s_axis_tready;
    sof_acc = acc && s_axis_tuser && state_q != IDLE;
    acc_frame = acc && (in_frame || sof_acc);
    // an accepted SOF beat is line 0 of the new frame, measured against the new sizes
    line_e = sof_acc ? '0 : line_q;
    vsize_e = sof_acc ? cfg_vsize : vsize_q;
    pass_frame = sof_acc ? skip_q == 4'd0 : state_q == PASS;
    eof = acc_frame && s_axis_tlast && line_e == vsize_e - DIM_WIDTH'(1);
    ds_col_down = (s_axis_tvalid && s_axis_tuser && state_q != IDLE) ? cfg_col_down : col_q;
    ds_line_down = (s_axis_tvalid && s_axis_tuser && state_q != IDLE) ? cfg_line_down : lin_q;
    state_d = (state_q == IDLE || eof) ? (cfg_enable ? WAIT_SOF : IDLE)
            : sof_acc ? (skip_q == 4'd0 ? PASS : DROP) : state_q;
    line_d = acc_frame ? line_e + DIM_WIDTH'(s_axis_tlast) : line_q;
    vsize_d = vsize_e;
    col_d = sof_acc ? cfg_col_down : col_q;
    lin_d = sof_acc ? cfg_line_down : lin_q;
    skip_d = eof ? (pass_frame ? cfg_frame_skip : skip_q - 4'(skip_q != 4'd0)) : skip_q;
    frame_cnt_d = frame_cnt_q + DIM_WIDTH'(eof && pass_frame);
    done_d = eof;
  end
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q <= IDLE;
      skip_q <= '0;
      line_q <= '0;
      vsize_q <= '0;
      frame_cnt_q <= '0;
      col_q <= 1'b0;
      lin_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      skip_q <= skip_d;
      line_q <= line_d;
      vsize_q <= vsize_d;
      frame_cnt_q <= frame_cnt_d;
      col_q <= col_d;
      lin_q <= lin_d;
      done_q <= done_d;
    end
  end
`ifdef V_DSAMPLER_CTRL_ERR_EN
  logic [DIM_WIDTH-1:0] beat_q, beat_d, beat_e, hsize_q, hsize_d, hsize_e;
  logic eol_early_q, eol_early_d, eol_late_q, eol_late_d, sof_early_q, sof_early_d;
  always_comb begin
    beat_e = sof_acc ? '0 : beat_q;
    hsize_e = sof_acc ? cfg_hsize : hsize_q;
    hsize_d = hsize_e;
    beat_d = acc_frame ? (s_axis_tlast ? '0 : beat_e + DIM_WIDTH'(1)) : beat_q;
    // a new error in the clearing cycle wins over the clear
    eol_early_d = (acc_frame && s_axis_tlast && beat_e < hsize_e - DIM_WIDTH'(1)) || (eol_early_q && !cfg_err_clr);
    eol_late_d = (acc_frame && !s_axis_tlast && beat_e == hsize_e - DIM_WIDTH'(1)) || (eol_late_q && !cfg_err_clr);
    sof_early_d = (sof_acc && in_frame) || (sof_early_q && !cfg_err_clr);
    err_eol_early = eol_early_q;
    err_eol_late = eol_late_q;
    err_sof_early = sof_early_q;
  end
  always_ff @(posedge aclk) begin
    if (areset) begin
      beat_q <= '0;
      hsize_q <= '0;
      eol_early_q <= 1'b0;
      eol_late_q <= 1'b0;
      sof_early_q <= 1'b0;
    end else begin
      beat_q <= beat_d;
      hsize_q <= hsize_d;
      eol_early_q <= eol_early_d;
      eol_late_q <= eol_late_d;
      sof_early_q <= sof_early_d;
    end
  end
`else
  logic unused_hsize;
  assign unused_hsize = ^cfg_hsize;
`endif
endmodule
